// File: rtl/wrr_mem_arbiter.sv
// N-port weighted round-robin arbiter for memory requests feeding one registered output stage.
// Each chosen port keeps the grant for up to max(weight,1) consecutive requests.
module wrr_mem_arbiter #(
   parameter int unsigned NUM_INPUT_PORT = 4,
   parameter int unsigned ADDR_WIDTH     = 27,
   parameter int unsigned WEIGHT_WIDTH   = 4,
   localparam int unsigned PORT_W = (NUM_INPUT_PORT > 1) ? $clog2(NUM_INPUT_PORT) : 1
) (
   input  logic                                 clk,
   input  logic                                 reset_n,
   input  logic [NUM_INPUT_PORT-1:0]            in_read,
   input  logic [NUM_INPUT_PORT-1:0]            in_write,
   input  logic [NUM_INPUT_PORT*ADDR_WIDTH-1:0] in_address,
   input  logic [NUM_INPUT_PORT*WEIGHT_WIDTH-1:0] weight,
   output logic [NUM_INPUT_PORT-1:0]            grant,
   output logic                                 out_valid,
   output logic                                 out_read,
   output logic                                 out_write,
   output logic [ADDR_WIDTH-1:0]                out_address,
   output logic [PORT_W-1:0]                    out_port,
   input  logic                                 out_port_ready
);

   localparam logic [PORT_W-1:0] LastPort = PORT_W'(NUM_INPUT_PORT - 1);

   // Arbitration state
   logic [PORT_W-1:0]       owner_q, owner_d;
   logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;
   logic                    owner_active_q, owner_active_d;

   // Output register
   logic                    out_valid_q, out_valid_d;
   logic                    out_read_q, out_read_d;
   logic                    out_write_q, out_write_d;
   logic [ADDR_WIDTH-1:0]   out_address_q, out_address_d;
   logic [PORT_W-1:0]       out_port_q, out_port_d;

   // Per-port unpacked views
   logic [ADDR_WIDTH-1:0]   addr_arr [NUM_INPUT_PORT];
   logic [WEIGHT_WIDTH-1:0] weight_arr [NUM_INPUT_PORT];

   logic [NUM_INPUT_PORT-1:0] req;
   logic                      slot_free;
   logic                      keep_owner;
   logic                      found;
   logic [PORT_W-1:0]         pick;
   logic [WEIGHT_WIDTH-1:0]   pick_weight;
   logic [WEIGHT_WIDTH-1:0]   pick_credit;
   logic                      do_grant;
   logic [PORT_W-1:0]         gnt_idx;
   int unsigned               search_idx;

   always_comb begin
      for (int i = 0; i < int'(NUM_INPUT_PORT); i++) begin
         addr_arr[i]   = in_address[i*ADDR_WIDTH +: ADDR_WIDTH];
         weight_arr[i] = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
      end
   end

   assign req        = in_read | in_write;
   assign slot_free  = !out_valid_q || out_port_ready;
   assign keep_owner = owner_active_q && req[owner_q] && (credit_q != '0);

   // Rotating search starting just after the owner; the owner itself is tried last.
   always_comb begin
      found      = 1'b0;
      pick       = owner_q;
      search_idx = 0;
      for (int k = 1; k <= int'(NUM_INPUT_PORT); k++) begin
         search_idx = int'(owner_q) + k;
         if (search_idx >= NUM_INPUT_PORT) begin
            search_idx = search_idx - NUM_INPUT_PORT;
         end
         if (!found && req[PORT_W'(search_idx)]) begin
            found = 1'b1;
            pick  = PORT_W'(search_idx);
         end
      end
   end

   // A zero weight is treated as one grant per turn.
   assign pick_weight = weight_arr[pick];
   assign pick_credit = (pick_weight == '0) ? '0 : pick_weight - 1'b1;

   always_comb begin
      owner_d        = owner_q;
      credit_d       = credit_q;
      owner_active_d = owner_active_q;
      do_grant       = 1'b0;
      gnt_idx        = owner_q;

      if (slot_free) begin
         if (keep_owner) begin
            do_grant = 1'b1;
            gnt_idx  = owner_q;
            credit_d = credit_q - 1'b1;
         end else if (found) begin
            do_grant       = 1'b1;
            gnt_idx        = pick;
            owner_d        = pick;
            credit_d       = pick_credit;
            owner_active_d = 1'b1;
         end else begin
            owner_active_d = 1'b0;
         end
      end
   end

   always_comb begin
      grant = '0;
      if (do_grant && reset_n) begin
         grant[gnt_idx] = 1'b1;
      end
   end

   always_comb begin
      out_valid_d   = out_valid_q;
      out_read_d    = out_read_q;
      out_write_d   = out_write_q;
      out_address_d = out_address_q;
      out_port_d    = out_port_q;

      if (slot_free) begin
         if (do_grant) begin
            out_valid_d   = 1'b1;
            out_read_d    = in_read[gnt_idx];
            out_write_d   = in_write[gnt_idx];
            out_address_d = addr_arr[gnt_idx];
            out_port_d    = gnt_idx;
         end else begin
            // Slot drained with nothing to replace it: data fields keep their last values.
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         owner_q        <= LastPort;
         credit_q       <= '0;
         owner_active_q <= 1'b0;
         out_valid_q    <= 1'b0;
         out_read_q     <= 1'b0;
         out_write_q    <= 1'b0;
         out_address_q  <= '0;
         out_port_q     <= '0;
      end else begin
         owner_q        <= owner_d;
         credit_q       <= credit_d;
         owner_active_q <= owner_active_d;
         out_valid_q    <= out_valid_d;
         out_read_q     <= out_read_d;
         out_write_q    <= out_write_d;
         out_address_q  <= out_address_d;
         out_port_q     <= out_port_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign out_read    = out_read_q;
   assign out_write   = out_write_q;
   assign out_address = out_address_q;
   assign out_port    = out_port_q;

`ifndef SYNTHESIS
   a_grant_onehot : assert property (@(posedge clk) disable iff (!reset_n) $onehot0(grant));

   a_stall_no_grant : assert property (@(posedge clk) disable iff (!reset_n)
      (out_valid_q && !out_port_ready) |-> (grant == '0));

   a_stall_stable : assert property (@(posedge clk) disable iff (!reset_n)
      (out_valid_q && !out_port_ready) |=>
         (out_valid_q && $stable(out_address_q) && $stable(out_port_q) &&
          $stable(out_read_q) && $stable(out_write_q)));
`endif

endmodule

// File: tb/tb_wrr_mem_arbiter.sv
// Directed bench for wrr_mem_arbiter: fixed grant/port sequences with hand-computed expectations.
module tb_wrr_mem_arbiter;

   localparam int unsigned N  = 4;
   localparam int unsigned AW = 27;
   localparam int unsigned WW = 4;
   localparam int unsigned PW = 2;

   logic              clk;
   logic              reset_n;
   logic [N-1:0]      in_read;
   logic [N-1:0]      in_write;
   logic [N*AW-1:0]   in_address;
   logic [N*WW-1:0]   weight;
   logic [N-1:0]      grant;
   logic              out_valid;
   logic              out_read;
   logic              out_write;
   logic [AW-1:0]     out_address;
   logic [PW-1:0]     out_port;
   logic              out_port_ready;

   int n_cmp;
   int n_err;

   wrr_mem_arbiter #(
      .NUM_INPUT_PORT(N),
      .ADDR_WIDTH    (AW),
      .WEIGHT_WIDTH  (WW)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .in_read       (in_read),
      .in_write      (in_write),
      .in_address    (in_address),
      .weight        (weight),
      .grant         (grant),
      .out_valid     (out_valid),
      .out_read      (out_read),
      .out_write     (out_write),
      .out_address   (out_address),
      .out_port      (out_port),
      .out_port_ready(out_port_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic set_port(input int p, input logic rd, input logic wr, input logic [AW-1:0] a);
      in_read[p]             = rd;
      in_write[p]            = wr;
      in_address[p*AW +: AW] = a;
   endtask

   task automatic set_weight(input int p, input logic [WW-1:0] w);
      weight[p*WW +: WW] = w;
   endtask

   // Leaves the bench 1 time unit after a rising edge with reset released.
   task automatic do_reset();
      reset_n        = 1'b0;
      in_read        = '0;
      in_write       = '0;
      in_address     = '0;
      out_port_ready = 1'b1;
      for (int i = 0; i < int'(N); i++) set_weight(i, 4'd1);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   // Check the combinational grant for this cycle, then the registered result after the edge.
   task automatic step(input string tag, input logic [N-1:0] exp_gnt, input logic [PW-1:0] exp_port);
      #1;
      check_eq({tag, "_grant"}, 32'(grant), 32'(exp_gnt));
      @(posedge clk);
      #1;
      if (exp_gnt != '0) begin
         check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
         check_eq({tag, "_port"}, 32'(out_port), 32'(exp_port));
      end
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset_n        = 1'b0;
      in_read        = '0;
      in_write       = '0;
      in_address     = '0;
      weight         = '0;
      out_port_ready = 1'b1;
      #1;
      check_eq("rst_valid", 32'(out_valid), 32'd0);
      check_eq("rst_read", 32'(out_read), 32'd0);
      check_eq("rst_write", 32'(out_write), 32'd0);
      check_eq("rst_addr", 32'(out_address), 32'd0);
      check_eq("rst_port", 32'(out_port), 32'd0);
      check_eq("rst_grant", 32'(grant), 32'd0);

      // 1: single reader on port 0
      do_reset();
      set_port(0, 1'b1, 1'b0, 27'h8);
      for (int c = 0; c < 3; c++) begin
         step("t1", 4'b0001, 2'd0);
         check_eq("t1_read", 32'(out_read), 32'd1);
         check_eq("t1_addr", 32'(out_address), 32'h8);
      end
      set_port(0, 1'b0, 1'b0, 27'h0);
      step("t1_idle", 4'b0000, 2'd0);
      check_eq("t1_drain_valid", 32'(out_valid), 32'd0);
      check_eq("t1_drain_addr", 32'(out_address), 32'h8);

      // 2: two ports, weight 1, alternate; port 1 also exercises read+write together
      do_reset();
      set_port(0, 1'b1, 1'b0, 27'h10);
      set_port(1, 1'b1, 1'b1, 27'h20);
      step("t2a", 4'b0001, 2'd0);
      step("t2b", 4'b0010, 2'd1);
      check_eq("t2_rdwr", 32'({out_read, out_write}), 32'b11);
      check_eq("t2_addr", 32'(out_address), 32'h20);
      step("t2c", 4'b0001, 2'd0);
      step("t2d", 4'b0010, 2'd1);

      // 3: weights p0=3, p1=1
      do_reset();
      set_weight(0, 4'd3);
      set_port(0, 1'b1, 1'b0, 27'h10);
      set_port(1, 1'b0, 1'b1, 27'h20);
      for (int r = 0; r < 2; r++) begin
         step("t3_p0a", 4'b0001, 2'd0);
         step("t3_p0b", 4'b0001, 2'd0);
         step("t3_p0c", 4'b0001, 2'd0);
         step("t3_p1", 4'b0010, 2'd1);
      end

      // 4: ports 2 and 3 from idle, search wraps past owner 3
      do_reset();
      set_port(2, 1'b1, 1'b0, 27'h30);
      set_port(3, 1'b1, 1'b0, 27'h40);
      step("t4a", 4'b0100, 2'd2);
      step("t4b", 4'b1000, 2'd3);
      step("t4c", 4'b0100, 2'd2);

      // 5: backpressure mid-burst must not consume credit
      do_reset();
      set_weight(1, 4'd3);
      set_port(1, 1'b1, 1'b0, 27'hA4);
      step("t5_first", 4'b0010, 2'd1);
      check_eq("t5_addr0", 32'(out_address), 32'hA4);
      out_port_ready = 1'b0;
      set_port(1, 1'b1, 1'b0, 27'hB0);
      set_port(0, 1'b1, 1'b0, 27'h11);
      for (int c = 0; c < 3; c++) begin
         #1;
         check_eq("t5_stall_grant", 32'(grant), 32'd0);
         @(posedge clk);
         #1;
         check_eq("t5_stall_valid", 32'(out_valid), 32'd1);
         check_eq("t5_stall_addr", 32'(out_address), 32'hA4);
         check_eq("t5_stall_port", 32'(out_port), 32'd1);
      end
      out_port_ready = 1'b1;
      step("t5_resume1", 4'b0010, 2'd1);
      check_eq("t5_addr1", 32'(out_address), 32'hB0);
      step("t5_resume2", 4'b0010, 2'd1);
      step("t5_next", 4'b0001, 2'd0);

      // 6: reset mid-burst gives a fresh full burst afterwards
      do_reset();
      set_weight(0, 4'd4);
      set_port(0, 1'b1, 1'b0, 27'h50);
      set_port(1, 1'b1, 1'b0, 27'h60);
      step("t6_pre1", 4'b0001, 2'd0);
      step("t6_pre2", 4'b0001, 2'd0);
      #1;
      reset_n = 1'b0;
      #1;
      check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
      check_eq("t6_rst_grant", 32'(grant), 32'd0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      for (int c = 0; c < 4; c++) step("t6_burst", 4'b0001, 2'd0);
      step("t6_p1", 4'b0010, 2'd1);

      // 7: weight 0 on port 1 behaves as weight 1
      do_reset();
      set_weight(1, 4'd0);
      set_port(1, 1'b1, 1'b0, 27'h70);
      set_port(2, 1'b1, 1'b0, 27'h80);
      step("t7a", 4'b0010, 2'd1);
      step("t7b", 4'b0100, 2'd2);
      step("t7c", 4'b0010, 2'd1);
      step("t7d", 4'b0100, 2'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
